// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding, STAT layout.
package irq_pkg;

    localparam logic [1:0] IRQ_ADDR_PEND = 2'd0;
    localparam logic [1:0] IRQ_ADDR_MASK = 2'd1;
    localparam logic [1:0] IRQ_ADDR_STAT = 2'd2;
    localparam logic [1:0] IRQ_ADDR_EOI  = 2'd3;

    typedef enum logic [1:0] {
        IRQ_ST_IDLE = 2'd0,
        IRQ_ST_REQ  = 2'd1,
        IRQ_ST_SERV = 2'd2
    } irq_state_e;

    localparam int unsigned IRQ_STAT_REQ_BIT  = 8;
    localparam int unsigned IRQ_STAT_SERV_BIT = 9;
    localparam int unsigned IRQ_STAT_ST_LSB   = 16;

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral-bus and CPU interrupt handshake bundle for irq_controller.
interface irq_controller_if #(
    parameter int unsigned VEC_W = 4
) ();

    logic             MemWrite;
    logic [1:0]       address;
    logic [31:0]      write_data;
    logic [31:0]      read_data;
    logic             irq_req;
    logic [VEC_W-1:0] irq_vector;
    logic             irq_ack;

    modport master (
        output MemWrite, address, write_data, irq_ack,
        input  read_data, irq_req, irq_vector
    );

    modport slave (
        input  MemWrite, address, write_data, irq_ack,
        output read_data, irq_req, irq_vector
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder: index 0 wins.
module irq_prio_enc #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned VEC_W = 4
) (
    input  logic [N_SRC-1:0] req_i,
    output logic [VEC_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o = '0;
        // Scan downwards so the lowest set index is the last write.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = VEC_W'(i);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/irq_controller.sv
// Edge-latching, maskable, fixed-priority interrupt controller with EOI handshake.
// Optional IRQ_SYNC_EN inserts a 2-flop synchronizer on irq_src before edge detection.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned VEC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    irq_controller_if.slave  bus
);

    logic [N_SRC-1:0] src_s, prev_q, edges;
    logic [N_SRC-1:0] pend_q, pend_d, mask_q, mask_d;
    logic [N_SRC-1:0] eligible, sw_clr, ack_clr, vec_sel;
    irq_state_e       state_q, state_d;
    logic             irq_req_q, irq_req_d;
    logic [VEC_W-1:0] vec_q, vec_d, enc_idx;
    logic             enc_valid;
    logic             wr_pend, wr_mask, wr_eoi;
    logic [31:0]      stat;
    logic             unused_wdata;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    assign wr_pend      = bus.MemWrite && (bus.address == IRQ_ADDR_PEND);
    assign wr_mask      = bus.MemWrite && (bus.address == IRQ_ADDR_MASK);
    assign wr_eoi       = bus.MemWrite && (bus.address == IRQ_ADDR_EOI);
    assign unused_wdata = ^bus.write_data[31:N_SRC];

    assign edges    = src_s & ~prev_q;
    assign eligible = pend_q & mask_q;
    assign vec_sel  = N_SRC'(1) << vec_q;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .VEC_W (VEC_W)
    ) u_prio_enc (
        .req_i   (eligible),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        sw_clr  = wr_pend ? bus.write_data[N_SRC-1:0] : '0;
        ack_clr = (state_q == IRQ_ST_REQ && bus.irq_ack) ? vec_sel : '0;
        // New edges are OR-ed in last so a simultaneous set beats any clear.
        pend_d  = (pend_q & ~(sw_clr | ack_clr)) | edges;
        mask_d  = wr_mask ? bus.write_data[N_SRC-1:0] : mask_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IRQ_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IRQ_ST_IDLE: if (enc_valid) state_d = IRQ_ST_REQ;
            IRQ_ST_REQ: begin
                // Retract once the requested source is no longer pending-and-enabled.
                if (bus.irq_ack) state_d = IRQ_ST_SERV;
                else if (~|(pend_d & mask_d & vec_sel)) state_d = IRQ_ST_IDLE;
            end
            IRQ_ST_SERV: if (wr_eoi) state_d = IRQ_ST_IDLE;
            default: state_d = IRQ_ST_IDLE;
        endcase
    end

    always_comb begin
        irq_req_d = (state_d == IRQ_ST_REQ);
        vec_d     = (state_q == IRQ_ST_IDLE && enc_valid) ? enc_idx : vec_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q    <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            irq_req_q <= 1'b0;
            vec_q     <= '0;
        end else begin
            prev_q    <= src_s;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            irq_req_q <= irq_req_d;
            vec_q     <= vec_d;
        end
    end

    always_comb begin
        stat                                 = '0;
        stat[VEC_W-1:0]                      = vec_q;
        stat[IRQ_STAT_REQ_BIT]               = irq_req_q;
        stat[IRQ_STAT_SERV_BIT]              = (state_q == IRQ_ST_SERV);
        stat[IRQ_STAT_ST_LSB +: 2]           = state_q;
    end

    always_comb begin
        bus.read_data = '0;
        unique case (bus.address)
            IRQ_ADDR_PEND: bus.read_data = 32'(pend_q);
            IRQ_ADDR_MASK: bus.read_data = 32'(mask_q);
            IRQ_ADDR_STAT: bus.read_data = stat;
            default:       bus.read_data = '0;
        endcase
    end

    assign bus.irq_req    = irq_req_q;
    assign bus.irq_vector = vec_q;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller: the receiving end of the `IRQ` lines driven by peripherals such as the timer.
- Latches rising edges on up to `N_SRC` device IRQ lines, applies a software mask and picks the highest-priority source.
- Presents a single request plus vector to the pipelined CPU, then holds that source in service until software writes end-of-interrupt (EOI).
- Sits on the same peripheral bus as the other external devices: `MemWrite`, 2-bit word address, 32-bit data.

Parameters:
- `N_SRC`, 4: number of interrupt source lines (1..16). Index 0 has the highest priority.
- `VEC_W`, 4: width of the vector output. Must satisfy 2^`VEC_W` >= `N_SRC`.

Ports:
- `clk`  in  1  system clock, all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  bus write strobe for this device (already address-decoded).
- `address`  in  2  word address: 0 PEND, 1 MASK, 2 STAT, 3 EOI.
- `write_data`  in  32  bus write data.
- `read_data`  out  32  combinational read of the register at `address`.
- `irq_src`  in  `N_SRC`  device IRQ lines, level-high.
- `irq_req`  out  1  interrupt request to CPU, registered.
- `irq_vector`  out  `VEC_W`  index of the requested or in-service source, registered.
- `irq_ack`  in  1  CPU accepts the request (one-cycle pulse).

Behaviour:
- Reset (`reset`=0, asynchronous): clears PEND, MASK, the edge-history register, state (=IDLE), `irq_req` and `irq_vector`. `read_data` then reads 0 at every address.
- Edge detection:
  - `prev` register holds `irq_src` from the previous cycle.
  - Rising edge when `irq_src[i]`=1 and `prev[i]`=0. `pending[i]` is set at that posedge and is visible the following cycle.
  - A line held high does not re-trigger.
- PEND (addr 0):
  - Read returns `pending`, zero-extended.
  - Write is write-1-to-clear: `pending &= ~write_data[N_SRC-1:0]`.
  - If a new edge and a clear hit the same bit in the same cycle, set wins.
- MASK (addr 1): read/write, bit i = 1 enables source i. Masked sources still latch into PEND.
- STAT (addr 2), read-only:
  - [`VEC_W`-1:0] = `irq_vector`.
  - [8] = `irq_req`.
  - [9] = in-service flag.
  - [17:16] = state encoding: IDLE=0, REQ=1, SERV=2.
  - All other bits 0. Writes are ignored.
- EOI (addr 3): a write in state SERV returns to IDLE. A write in any other state is ignored. Reads return 0.
- State machine:
  - IDLE: when `eligible = pending & mask` is nonzero, at the next posedge go to REQ, set `irq_req`=1 and latch `irq_vector` = lowest set index of `eligible`.
  - REQ:
    - Hold `irq_req` and `irq_vector` stable; a newly arriving higher-priority source does not change the vector.
    - On `irq_ack`=1: go to SERV, `irq_req`=0, clear `pending[irq_vector]` (set-wins rule still applies).
    - If software clears that pending bit or masks it before ack: retract, i.e. `irq_req`=0 and go to IDLE. Arbitration reruns from IDLE the next cycle.
  - SERV: `irq_vector` holds; no new request is issued until EOI. Edges keep latching into PEND.
  - `irq_ack` outside REQ is ignored.
- Latency:
  - Source edge sampled at cycle T → `pending` at T+1 → `irq_req` at T+2 (unmasked, state IDLE).
  - EOI write at T with another source eligible → IDLE at T+1 → `irq_req` at T+2.
- Bus writes and IRQ events in the same cycle are both honoured; no arbitration stall.
- Reset mid-operation: returns to IDLE immediately and drops `irq_req`. The CPU must treat a pending ack as void.

Optional Feature:
- `IRQ_SYNC_EN`
  - Defined: `irq_src` passes through a 2-flop synchronizer (reset to 0) before edge detection. Adds 2 cycles, so the edge sampled at T gives `irq_req` at T+4. Use for asynchronous sources.
  - Undefined: `irq_src` is assumed synchronous to `clk`, with latency as above.

Decomposition:
- Shared package `irq_pkg`:
  - register address constants: `IRQ_ADDR_PEND`=0, `IRQ_ADDR_MASK`=1, `IRQ_ADDR_STAT`=2, `IRQ_ADDR_EOI`=3;
  - state encodings `IRQ_ST_IDLE`/`IRQ_ST_REQ`/`IRQ_ST_SERV`;
  - STAT bit positions.
- One natural sub-module, `irq_prio_enc`: combinational lowest-set-bit priority encoder, `N_SRC` → `VEC_W` plus valid.

Test Plan:
- After reset, write MASK=0xF; pulse `irq_src[2]` high at cycle T → PEND=0x4 at T+1, `irq_req`=1 with `irq_vector`=2 at T+2; STAT reads 0x00010102.
- Edges on sources 3 and 1 in the same cycle → vector=1. After ack + EOI, `irq_req` returns with vector=3 two cycles later; PEND=0x8 before the second ack.
- MASK=0x0, edge on source 0 → PEND=0x1, `irq_req` stays 0. Write MASK=0x1 → `irq_req`=1 with vector 0 one cycle later.
- In REQ, write PEND=0x1 (clear) before ack → `irq_req` drops next cycle, state IDLE. In the same cycle as a clear of bit 2, a new edge on bit 2 → PEND bit 2 stays 1.
- In SERV, raise source 0 → no `irq_req` until EOI. EOI in IDLE has no effect. Assert `reset`=0 while in REQ → `irq_req`=0, PEND=0 asynchronously.
- With `IRQ_SYNC_EN` defined: edge on source 1 sampled at T → `irq_req` at T+4; a line held high for 10 cycles produces exactly one pending event.
